// File: rtl/qk_score_buffer.sv
// qk_score_buffer: captures multi-row score groups from the matmul, scales each
// element by 2^-SCALE_SHIFT (round-half-up) and streams them one row per beat.
//
// Handshake: the input side is a single-cycle in_valid pulse. It is accepted
// only while in_ready=1 and is dropped (overflow goes sticky) otherwise. On the
// output side, a beat transfers on any rising edge where out_valid && out_ready.
// out_valid never drops and out_data/out_row never change while a beat is
// pending. The only exception is the asynchronous reset.
module qk_score_buffer #(
  parameter int WIDTH_OUT      = 16,
  parameter int FRAC_WIDTH_OUT = 8,
  parameter int ELEMS_PER_ROW  = 8,
  parameter int TOTAL_INPUT_W  = 2,
  parameter int SCALE_SHIFT    = 2,
  parameter int DEPTH          = 4,
  parameter int TOTAL_GROUPS   = 16,
  localparam int ROW_W         = WIDTH_OUT * ELEMS_PER_ROW,
  localparam int ROW_IDX_W     = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ROW_W-1:0]     in_data [TOTAL_INPUT_W],
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_W-1:0]     out_data,
  output logic [ROW_IDX_W-1:0] out_row,
  output logic                 out_last,
  output logic                 head_done,
  output logic                 overflow,
  output logic                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GRP_W = (TOTAL_GROUPS > 1) ? $clog2(TOTAL_GROUPS) : 1;

  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(TOTAL_INPUT_W - 1);
  localparam logic [GRP_W-1:0]     LAST_GRP = GRP_W'(TOTAL_GROUPS - 1);
  // Half an output LSB; evaluates to 0 when SCALE_SHIFT is 0 (pass-through).
  localparam logic signed [WIDTH_OUT:0] RND = (WIDTH_OUT + 1)'((2 ** SCALE_SHIFT) / 2);

  // The Q format is unchanged by scaling, so FRAC_WIDTH_OUT only needs to be sane.
  if (SCALE_SHIFT < 0 || SCALE_SHIFT >= WIDTH_OUT || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || FRAC_WIDTH_OUT < 0 ||
      FRAC_WIDTH_OUT > WIDTH_OUT) begin : g_bad_params
    $error("qk_score_buffer: illegal parameter combination");
  end

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ROW_IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [GRP_W-1:0]       group_cnt_q, group_cnt_d;
  logic                   head_done_q, head_done_d;
  logic                   overflow_q, overflow_d;

  logic [ROW_W-1:0]       mem_q [DEPTH][TOTAL_INPUT_W];
  logic [ROW_W-1:0]       scaled_rows [TOTAL_INPUT_W];
  logic                   push, beat, pop_last;

  // Sign-extend, add half an LSB, arithmetic shift. The result always fits in WIDTH_OUT.
  function automatic logic [WIDTH_OUT-1:0] scale_elem(input logic [WIDTH_OUT-1:0] x);
    logic signed [WIDTH_OUT:0] sum;
    sum = $signed({x[WIDTH_OUT-1], x}) + RND;
    return WIDTH_OUT'(sum >>> SCALE_SHIFT);
  endfunction

  // Scale every element of the incoming group so it is ready at the capture edge.
  always_comb begin
    for (int r = 0; r < TOTAL_INPUT_W; r++) begin
      scaled_rows[r] = '0;
      for (int e = 0; e < ELEMS_PER_ROW; e++) begin
        scaled_rows[r][e*WIDTH_OUT +: WIDTH_OUT] =
          scale_elem(in_data[r][e*WIDTH_OUT +: WIDTH_OUT]);
      end
    end
  end

  // Group storage: written only on capture, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int r = 0; r < TOTAL_INPUT_W; r++) begin
        mem_q[wr_ptr_q][r] <= scaled_rows[r];
      end
    end
  end

  // Next-state logic for pointers, occupancy, row/group counters and the output FSM.
  always_comb begin
    push        = in_valid && (count_q != FULL_CNT);
    beat        = (state_q == STREAM) && out_ready;
    pop_last    = beat && (row_cnt_q == LAST_ROW);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    row_cnt_d   = row_cnt_q;
    group_cnt_d = group_cnt_q;
    head_done_d = 1'b0;
    overflow_d  = overflow_q | (in_valid && (count_q == FULL_CNT));

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (beat) begin
      row_cnt_d = pop_last ? '0 : row_cnt_q + ROW_IDX_W'(1);
    end
    if (pop_last) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      head_done_d = (group_cnt_q == LAST_GRP);
      group_cnt_d = (group_cnt_q == LAST_GRP) ? '0 : group_cnt_q + GRP_W'(1);
    end
    case ({push, pop_last})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    state_d = (count_d != '0) ? STREAM : IDLE;
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      row_cnt_q   <= '0;
      group_cnt_q <= '0;
      head_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_cnt_q   <= row_cnt_d;
      group_cnt_q <= group_cnt_d;
      head_done_q <= head_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (state_q == STREAM);
  assign out_data  = mem_q[rd_ptr_q][row_cnt_q];
  assign out_row   = row_cnt_q;
  assign out_last  = out_valid && (row_cnt_q == LAST_ROW);
  assign head_done = head_done_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
